// File: rtl/robo_controle.sv
// Left-hand wall-following navigation controller for the pipe-cleaner robot.
// Issues one-cycle acao pulses to the map stage and tracks the robot's cell position.
`timescale 1ns/1ps
module robo_controle #(
    parameter int         LINHAS      = 10,
    parameter int         COLUNAS     = 20,
    parameter int         LINHA_INI   = 9,
    parameter int         COLUNA_INI  = 17,
    parameter logic [2:0] ORIENT_INI  = 3'b001,
    parameter int         MAX_PASSOS  = 1000,
    parameter int         MAX_LIMPEZA = 8
) (
    input  logic        clockc1,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [3:0]  head,
    input  logic [3:0]  left,
    input  logic        barreira,
    output logic [2:0]  acao,
    output logic [2:0]  orientacao,
    output logic        ocupado,
    output logic        concluido,
    output logic [15:0] passos,
    output logic [15:0] limpezas,
    output logic [7:0]  linha,
    output logic [7:0]  coluna
);
    localparam logic [2:0] OR_N = 3'b001, OR_W = 3'b010, OR_E = 3'b011, OR_S = 3'b100;
    localparam logic [2:0] AC_NADA = 3'b000, AC_LIMPA = 3'b101;
    localparam logic [7:0] L_ULT = 8'(LINHAS - 1);
    localparam logic [7:0] C_ULT = 8'(COLUNAS - 1);
    localparam logic [7:0] L_INI = 8'(LINHA_INI);
    localparam logic [7:0] C_INI = 8'(COLUNA_INI);
    localparam logic [15:0] P_MAX = 16'(MAX_PASSOS);
    localparam int CW = $clog2(MAX_LIMPEZA + 1);
    localparam logic [CW-1:0] CL_MAX = CW'(MAX_LIMPEZA);

    typedef enum logic [1:0] {OCIOSO, ASSENTA, DECIDE, CONCLUIDO} estado_t;

    estado_t       r_est, w_est_n;
    logic [2:0]    r_acao, w_acao_n, r_ori, w_ori_n;
    logic          r_ocup, r_conc, r_vira, w_vira_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [15:0]   r_passos, w_passos_n, r_limp, w_limp_n;
    logic [7:0]    r_lin, w_lin_n, r_col, w_col_n;
    logic [2:0]    w_esq, w_dir;
    logic          w_ori_ok, w_frente_ok, w_esq_ok, w_fim;

    // A step in direction dir from (lin,col) stays inside the map.
    function automatic logic dentro(input logic [2:0] dir, input logic [7:0] lin,
                                    input logic [7:0] col);
        case (dir)
            OR_N:    return lin != 8'd0;
            OR_S:    return lin != L_ULT;
            OR_W:    return col != 8'd0;
            OR_E:    return col != C_ULT;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        w_esq    = ORIENT_INI;
        w_dir    = ORIENT_INI;
        w_ori_ok = 1'b1;
        case (r_ori)
            OR_N:    begin w_esq = OR_W; w_dir = OR_E; end
            OR_W:    begin w_esq = OR_S; w_dir = OR_N; end
            OR_S:    begin w_esq = OR_E; w_dir = OR_W; end
            OR_E:    begin w_esq = OR_N; w_dir = OR_S; end
            default: w_ori_ok = 1'b0;
        endcase
    end

    assign w_frente_ok = dentro(r_ori, r_lin, r_col);
    assign w_esq_ok    = dentro(w_esq, r_lin, r_col);
    assign w_fim       = (r_passos == P_MAX) ||
                         (r_passos != 16'd0 && r_lin == L_INI && r_col == C_INI);

    always_comb begin
        w_est_n    = r_est;
        w_acao_n   = AC_NADA;
        w_ori_n    = r_ori;
        w_vira_n   = r_vira;
        w_cnt_n    = r_cnt;
        w_passos_n = r_passos;
        w_limp_n   = r_limp;
        w_lin_n    = r_lin;
        w_col_n    = r_col;
        case (r_est)
            OCIOSO: if (iniciar) begin
                w_est_n = ASSENTA;
                w_ori_n = ORIENT_INI;
            end
            ASSENTA: w_est_n = DECIDE;
            DECIDE: begin
                w_est_n = ASSENTA;
                if (w_fim) begin
                    w_est_n = CONCLUIDO;
                end else if (!w_ori_ok) begin
                    w_ori_n = ORIENT_INI;
                end else if (barreira && r_cnt < CL_MAX) begin
                    w_acao_n = AC_LIMPA;
                    w_limp_n = (r_limp == 16'hFFFF) ? r_limp : r_limp + 16'd1;
                    w_cnt_n  = r_cnt + CW'(1);
                end else if (left == 4'd0 && !r_vira && w_esq_ok) begin
                    w_ori_n  = w_esq;
                    w_vira_n = 1'b1;
                end else if (head == 4'd0 && !barreira && w_frente_ok) begin
                    w_acao_n   = r_ori;
                    w_passos_n = (r_passos == 16'hFFFF) ? r_passos : r_passos + 16'd1;
                    w_vira_n   = 1'b0;
                    w_cnt_n    = '0;
                    case (r_ori)
                        OR_N:    w_lin_n = r_lin - 8'd1;
                        OR_S:    w_lin_n = r_lin + 8'd1;
                        OR_W:    w_col_n = r_col - 8'd1;
                        default: w_col_n = r_col + 8'd1;
                    endcase
                end else begin
                    // Blocked ahead or debris that would not clear: rotate right.
                    w_ori_n  = w_dir;
                    w_vira_n = 1'b0;
                    w_cnt_n  = '0;
                end
            end
            CONCLUIDO: w_est_n = CONCLUIDO;
            default:   w_est_n = OCIOSO;
        endcase
    end

    always_ff @(posedge clockc1 or posedge reset) begin
        if (reset) begin
            r_est    <= OCIOSO;
            r_acao   <= AC_NADA;
            r_ori    <= ORIENT_INI;
            r_ocup   <= 1'b0;
            r_conc   <= 1'b0;
            r_vira   <= 1'b0;
            r_cnt    <= '0;
            r_passos <= 16'd0;
            r_limp   <= 16'd0;
            r_lin    <= L_INI;
            r_col    <= C_INI;
        end else begin
            r_est    <= w_est_n;
            r_acao   <= w_acao_n;
            r_ori    <= w_ori_n;
            r_ocup   <= (w_est_n == ASSENTA) || (w_est_n == DECIDE);
            r_conc   <= (w_est_n == CONCLUIDO);
            r_vira   <= w_vira_n;
            r_cnt    <= w_cnt_n;
            r_passos <= w_passos_n;
            r_limp   <= w_limp_n;
            r_lin    <= w_lin_n;
            r_col    <= w_col_n;
        end
    end

    assign acao       = r_acao;
    assign orientacao = r_ori;
    assign ocupado    = r_ocup;
    assign concluido  = r_conc;
    assign passos     = r_passos;
    assign limpezas   = r_limp;
    assign linha      = r_lin;
    assign coluna     = r_col;
endmodule

// File: tb/tb_robo_controle.sv
// Bench for robo_controle: emulated map stage over a grid world, high-level
// navigation model feeding a decision scoreboard, plus directed edge cases.
`timescale 1ns/1ps
module tb_robo_controle;
    localparam int LIN = 10, COL = 20, LI = 9, CI = 17, MAXL = 8, MAXP = 1000;

    logic clockc1 = 0, reset = 0, iniciar = 0, iniciar5 = 0;
    logic [3:0] head = 4'd1, left = 4'd1;
    logic barreira = 0;
    logic [2:0] acao, orientacao, acao5, orient5;
    logic ocupado, concluido, ocupado5, concluido5;
    logic [15:0] passos, limpezas, passos5, limp5;
    logic [7:0] linha, coluna, linha5, coluna5;

    always #5 clockc1 = ~clockc1;

    robo_controle u_dut (
        .clockc1(clockc1), .reset(reset), .iniciar(iniciar), .head(head), .left(left),
        .barreira(barreira), .acao(acao), .orientacao(orientacao), .ocupado(ocupado),
        .concluido(concluido), .passos(passos), .limpezas(limpezas), .linha(linha),
        .coluna(coluna));

    robo_controle #(.MAX_PASSOS(5)) u_dut5 (
        .clockc1(clockc1), .reset(reset), .iniciar(iniciar5), .head(4'd0), .left(4'hF),
        .barreira(1'b0), .acao(acao5), .orientacao(orient5), .ocupado(ocupado5),
        .concluido(concluido5), .passos(passos5), .limpezas(limp5), .linha(linha5),
        .coluna(coluna5));

    typedef struct packed {
        logic [2:0] a; logic [2:0] o; logic [15:0] p; logic [15:0] l;
        logic [7:0] r; logic [7:0] c; logic f;
    } rec_t;

    rec_t q[$];
    int checks = 0, errors = 0;
    bit mon_en = 0;
    bit wall[LIN][COL];
    int deb0[LIN][COL], e_deb[LIN][COL], m_deb[LIN][COL];
    int DR[4] = '{-1, 0, 1, 0};
    int DC[4] = '{0, -1, 0, 1};
    logic [2:0] CODE[4] = '{3'd1, 3'd2, 3'd4, 3'd3};
    int m_steps;

    function automatic bit inb(int r, int c);
        return r >= 0 && r < LIN && c >= 0 && c < COL;
    endfunction

    function automatic int o2i(logic [2:0] o);
        case (o)
            3'd2: return 1;
            3'd4: return 2;
            3'd3: return 3;
            default: return 0;
        endcase
    endfunction

    // Map stage: applies the command seen during the previous cycle, then re-registers sensors.
    initial begin
        int er, ec, d, ar, ac, lr, lc, mi;
        logic [2:0] a, o;
        er = LI; ec = CI;
        forever begin
            @(negedge clockc1);
            a = acao; o = orientacao;
            @(posedge clockc1);
            #1;
            if (reset) begin
                er = LI; ec = CI;
            end else begin
                d = o2i(o);
                if (a == 3'd5) begin
                    ar = er + DR[d]; ac = ec + DC[d];
                    if (inb(ar, ac) && e_deb[ar][ac] > 0) e_deb[ar][ac]--;
                end else if (a != 3'd0) begin
                    mi = o2i(a);
                    er += DR[mi]; ec += DC[mi];
                end
            end
            d  = o2i(orientacao);
            ar = er + DR[d]; ac = ec + DC[d];
            if (!inb(ar, ac) || wall[ar][ac]) begin
                head = 4'd1; barreira = 1'b0;
            end else begin
                head = 4'd0; barreira = (e_deb[ar][ac] > 0);
            end
            lr = er + DR[(d + 1) % 4]; lc = ec + DC[(d + 1) % 4];
            left = (!inb(lr, lc) || wall[lr][lc]) ? 4'd1 : 4'd0;
        end
    end

    // Every decision is visible as a command pulse, a heading change or completion.
    initial begin
        logic [2:0] prev_o;
        logic prev_c;
        rec_t got, exp;
        prev_o = 3'd1; prev_c = 1'b0;
        forever begin
            @(negedge clockc1);
            if (mon_en && (acao != 3'd0 || orientacao != prev_o || (concluido && !prev_c))
                && q.size() > 0) begin
                exp = q.pop_front();
                got = '{acao, orientacao, passos, limpezas, linha, coluna, concluido};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL decision: got a=%0d o=%0d p=%0d l=%0d r=%0d c=%0d f=%0d, expected a=%0d o=%0d p=%0d l=%0d r=%0d c=%0d f=%0d",
                             got.a, got.o, got.p, got.l, got.r, got.c, got.f,
                             exp.a, exp.o, exp.p, exp.l, exp.r, exp.c, exp.f);
                end
            end
            prev_o = orientacao; prev_c = concluido;
        end
    end

    // Left-hand rule over the world, directions indexed counter-clockwise from north.
    task automatic run_model(int maxdec);
        int r, c, d, cl, steps, cleans, ar, ac, lr, lc, k;
        bit turned, ain, awall, deb, lfree;
        r = LI; c = CI; d = 0; cl = 0; steps = 0; cleans = 0; turned = 0;
        m_deb = deb0;
        for (k = 0; k < maxdec; k++) begin
            if (steps == MAXP || (steps != 0 && r == LI && c == CI)) begin
                q.push_back('{3'd0, CODE[d], 16'(steps), 16'(cleans), 8'(r), 8'(c), 1'b1});
                break;
            end
            ar = r + DR[d]; ac = c + DC[d];
            ain = inb(ar, ac);
            awall = !ain || wall[ar][ac];
            deb = !awall && m_deb[ar][ac] > 0;
            lr = r + DR[(d + 1) % 4]; lc = c + DC[(d + 1) % 4];
            lfree = inb(lr, lc) && !wall[lr][lc];
            if (deb && cl < MAXL) begin
                m_deb[ar][ac]--; cleans++; cl++;
                q.push_back('{3'd5, CODE[d], 16'(steps), 16'(cleans), 8'(r), 8'(c), 1'b0});
            end else if (lfree && !turned) begin
                d = (d + 1) % 4; turned = 1;
                q.push_back('{3'd0, CODE[d], 16'(steps), 16'(cleans), 8'(r), 8'(c), 1'b0});
            end else if (!awall && !deb) begin
                r = ar; c = ac; steps++; turned = 0; cl = 0;
                q.push_back('{CODE[d], CODE[d], 16'(steps), 16'(cleans), 8'(r), 8'(c), 1'b0});
            end else begin
                d = (d + 3) % 4; turned = 0; cl = 0;
                q.push_back('{3'd0, CODE[d], 16'(steps), 16'(cleans), 8'(r), 8'(c), 1'b0});
            end
        end
        m_steps = steps;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic clear_world(bit w);
        for (int r = 0; r < LIN; r++)
            for (int c = 0; c < COL; c++) begin
                wall[r][c] = w; deb0[r][c] = 0;
            end
        wall[LI][CI] = 0;
    endtask

    task automatic corridor();
        clear_world(1);
        for (int r = 0; r < LIN; r++) wall[r][CI] = 0;
    endtask

    task automatic start_run(int maxdec);
        mon_en = 0;
        reset = 1;
        q.delete();
        e_deb = deb0;
        run_model(maxdec);
        repeat (2) @(posedge clockc1);
        @(negedge clockc1);
        reset = 0;
        @(negedge clockc1);
        mon_en = 1;
        iniciar = 1;
        @(negedge clockc1);
        iniciar = 0;
    endtask

    task automatic wait_drain(string nm, int budget);
        int n;
        n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clockc1);
            n++;
        end
        @(negedge clockc1);
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL %s drain: got %0d decisions pending, expected 0", nm, q.size());
        end
        mon_en = 0;
    endtask

    task automatic check_reset_vals(string nm);
        chk({nm, " acao"}, 32'(acao), 0);
        chk({nm, " orient"}, 32'(orientacao), 1);
        chk({nm, " ocupado"}, 32'(ocupado), 0);
        chk({nm, " concluido"}, 32'(concluido), 0);
        chk({nm, " passos"}, 32'(passos), 0);
        chk({nm, " limpezas"}, 32'(limpezas), 0);
        chk({nm, " linha"}, 32'(linha), LI);
        chk({nm, " coluna"}, 32'(coluna), CI);
    endtask

    task automatic check_done_hold(string nm, int steps);
        chk({nm, " concluido"}, 32'(concluido), 1);
        iniciar = 1;
        @(negedge clockc1);
        iniciar = 0;
        repeat (6) begin
            @(negedge clockc1);
            if (acao != 3'd0) chk({nm, " acao held"}, 32'(acao), 0);
        end
        chk({nm, " still done"}, 32'(concluido), 1);
        chk({nm, " ocupado"}, 32'(ocupado), 0);
        chk({nm, " passos"}, 32'(passos), 32'(steps));
    endtask

    initial begin
        int n;
        logic [2:0] pa;
        #1 reset = 1;
        #3 check_reset_vals("reset");
        repeat (2) @(posedge clockc1);
        @(negedge clockc1);
        reset = 0;

        // Step limit on the MAX_PASSOS=5 instance, plus command cadence.
        iniciar5 = 1;
        @(negedge clockc1);
        iniciar5 = 0;
        chk("lim5 ocupado", 32'(ocupado5), 1);
        n = 0; pa = 3'd0;
        while (!concluido5 && n < 100) begin
            @(negedge clockc1);
            if (pa != 3'd0) chk("lim5 cadence", 32'(acao5), 0);
            pa = acao5; n++;
        end
        chk("lim5 done", 32'(concluido5), 1);
        chk("lim5 passos", 32'(passos5), 5);
        chk("lim5 linha", 32'(linha5), LI - 5);
        chk("lim5 acao", 32'(acao5), 0);

        corridor();
        start_run(100);
        wait_drain("corridor", 400);
        check_done_hold("corridor", m_steps);

        clear_world(0);
        start_run(120);
        wait_drain("open", 400);

        corridor();
        deb0[7][CI] = 3;
        start_run(100);
        wait_drain("debris3", 400);

        corridor();
        deb0[8][CI] = 100;
        start_run(40);
        wait_drain("stuck", 200);

        clear_world(1);
        start_run(12);
        wait_drain("boxed", 100);

        clear_world(1);
        wall[8][CI] = 0; wall[8][CI-1] = 0; wall[9][CI-1] = 0;
        start_run(50);
        wait_drain("loop2x2", 200);
        check_done_hold("loop2x2", 4);

        for (int s = 0; s < 8; s++) begin
            clear_world(0);
            for (int r = 0; r < LIN; r++)
                for (int c = 0; c < COL; c++) begin
                    wall[r][c] = ($urandom_range(0, 9) < 3);
                    if (!wall[r][c] && $urandom_range(0, 9) == 0)
                        deb0[r][c] = $urandom_range(1, 11);
                end
            wall[LI][CI] = 0; deb0[LI][CI] = 0;
            start_run(150);
            wait_drain("random", 500);
        end

        // Asynchronous reset while a clean command is on the bus.
        corridor();
        deb0[7][CI] = 3;
        start_run(100);
        n = 0;
        while (acao != 3'd5 && n < 200) begin
            @(negedge clockc1);
            n++;
        end
        chk("clean seen", 32'(acao), 5);
        mon_en = 0;
        #2 reset = 1;
        #1 check_reset_vals("midreset");
        repeat (2) @(posedge clockc1);
        @(negedge clockc1);
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
